octal_display_scan_controller: RTL and testbench
================================================

# octal_display_scan_controller

Sequences the octal counter-plus-7-segment datapath: owns a 4-digit cascaded 3-bit counter and time-multiplexes one shared 7-segment decoder across four digit enables. Sits between board-level controls (run, step, up/down, clear) and a multiplexed 4-digit common-cathode display. Replaces the free-running ripple T-flip-flop chain with a fully synchronous, prescaled, scan-driven controller.

## Interface
- PRESCALE, default 4: clock cycles per count while running; legal range 1..65535.
- SCAN_DIV, default 2: clock cycles each digit stays enabled; legal range 1..65535.
- clk  in  1  single system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level: 1 = count every PRESCALE cycles, 0 = stopped.
- step  in  1  one count per cycle asserted while stopped; ignored while running.
- up_down  in  1  1 = count up, 0 = count down; sampled at each count.
- clear  in  1  synchronous clear of value and prescaler.
- value  out  12  counter, 4 octal digits; digit k = value[3k+2:3k].
- wrap  out  1  one-cycle pulse on counter wrap.
- running  out  1  1 while state is RUNNING.
- digit_en  out  4  one-hot active-high digit select.
- seg  out  8  active-high {dp,g,f,e,d,c,b,a} for the enabled digit.

## Operation
- Reset values: state STOPPED, value 0, prescaler 0, scan timer 0, scan index 0, wrap 0, running 0, digit_en 4'b0001, seg 8'h3F.
- FSM: STOPPED -> RUNNING when run=1; RUNNING -> STOPPED when run=0. Each transition clears the prescaler.
- Count event, priority order: clear, then running count, then step.
  - clear=1: value and prescaler become 0, wrap 0; state unaffected.
  - RUNNING and run=1: prescaler increments; at PRESCALE-1 it returns to 0 and a count event occurs on that edge.
  - STOPPED and step=1: a count event occurs on that edge.
- Count event: value ± 1 modulo 4096.
  - Up from 12'o7777 gives 0 with wrap=1.
  - Down from 0 gives 12'o7777 with wrap=1.
  - Otherwise wrap=0.
- Scan: scan timer counts 0..SCAN_DIV-1. At terminal it returns to 0 and the index advances 0→1→2→3→0. Scanning runs regardless of state or clear.
- Decode of the indexed digit: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07.
- dp (seg[7]) is set only when index=0 and state is RUNNING (heartbeat).

## Timing
- value, wrap and running update on the edge of the count event or transition; no further latency.
- digit_en and seg are registered from the current index and value. They lag index and value changes by exactly one cycle, and always change together, so there is no ghosting.
- After run rises, running=1 on the next edge. The first count occurs PRESCALE cycles after that edge.
- A run fall on the cycle the prescaler is terminal produces no count, because the state is still RUNNING but run=0.
- clear asserted together with a count or step: clear wins, with no wrap pulse.
- A step held N cycles while stopped gives N counts.
- rst mid-operation restores all reset values on the next edge, including any in-flight wrap pulse.

## Test plan
- Reset, then idle 10 cycles with run=0: value=0, wrap=0, running=0. digit_en cycles 0001,0010,0100,1000 every SCAN_DIV cycles; seg=3F throughout.
- PRESCALE=4, run=1, up_down=1 for 33 cycles: running=1 after 1 edge; value=8 after 33 cycles; dp set only while digit_en=0001.
- Load 12'o7776 via steps from 0 with up_down=0 (two steps give 7777, then 7776), then up_down=1 with two steps: value=7777, then 0 with wrap=1 for exactly one cycle.
- From value=0, step=1 and up_down=0 for one cycle: value=12'o7777, wrap=1. The next scan of digit 0 shows seg=07.
- Running with value=12'o0123, assert clear together with a terminal prescaler: value=0, no wrap. The prescaler restarts, and the next count occurs PRESCALE cycles later.
- Assert rst mid-count and mid-scan: on the next edge all outputs equal their reset values, including digit_en=0001 and seg=3F.

Source files
------------

// File: rtl/octal_display_scan_controller_if.sv
// Control inputs and display/counter outputs of the octal scan controller.
interface octal_display_scan_controller_if;
    logic        run;
    logic        step;
    logic        up_down;
    logic        clear;
    logic [11:0] value;
    logic        wrap;
    logic        running;
    logic [3:0]  digit_en;
    logic [7:0]  seg;

    modport master (
        output run, step, up_down, clear,
        input  value, wrap, running, digit_en, seg
    );

    modport slave (
        input  run, step, up_down, clear,
        output value, wrap, running, digit_en, seg
    );
endinterface

// File: rtl/octal_display_scan_controller.sv
// Prescaled 4-digit octal up/down counter with a time-multiplexed,
// registered 7-segment scan driver for a common-cathode display.
module octal_display_scan_controller #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned SCAN_DIV = 2
) (
    input logic                            clk,
    input logic                            rst,
    octal_display_scan_controller_if.slave ctrl
);
    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_e;

    localparam logic [15:0] PRE_LAST  = 16'(PRESCALE - 1);
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    state_e      state_q;
    logic [15:0] presc_q;
    logic [11:0] value_q, value_d;
    logic        wrap_q, wrap_d;
    logic        count_evt;
    logic [15:0] scan_q;
    logic [1:0]  idx_q;
    logic [3:0]  digit_en_q;
    logic [7:0]  seg_q, seg_d;
    logic [2:0]  digit;
    logic        presc_term;
    logic        transition;

    always_comb begin
        presc_term = (presc_q == PRE_LAST);
        transition = (state_q == STOPPED && ctrl.run) || (state_q == RUNNING && !ctrl.run);
        // clear suppresses any count, so no wrap can be reported alongside it
        count_evt  = !ctrl.clear &&
                     ((state_q == RUNNING && ctrl.run && presc_term) ||
                      (state_q == STOPPED && ctrl.step));
        value_d = value_q;
        wrap_d  = 1'b0;
        if (count_evt) begin
            if (ctrl.up_down) begin
                value_d = value_q + 12'd1;
                wrap_d  = (value_q == '1);
            end else begin
                value_d = value_q - 12'd1;
                wrap_d  = (value_q == '0);
            end
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    digit = value_q[2:0];
            2'd1:    digit = value_q[5:3];
            2'd2:    digit = value_q[8:6];
            default: digit = value_q[11:9];
        endcase
        seg_d = 8'h00;
        case (digit)
            3'd0:    seg_d[6:0] = 7'h3F;
            3'd1:    seg_d[6:0] = 7'h06;
            3'd2:    seg_d[6:0] = 7'h5B;
            3'd3:    seg_d[6:0] = 7'h4F;
            3'd4:    seg_d[6:0] = 7'h66;
            3'd5:    seg_d[6:0] = 7'h6D;
            3'd6:    seg_d[6:0] = 7'h7D;
            default: seg_d[6:0] = 7'h07;
        endcase
        seg_d[7] = (idx_q == 2'd0) && (state_q == RUNNING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= STOPPED;
            presc_q    <= '0;
            value_q    <= '0;
            wrap_q     <= 1'b0;
            scan_q     <= '0;
            idx_q      <= '0;
            digit_en_q <= 4'b0001;
            seg_q      <= 8'h3F;
        end else begin
            state_q <= ctrl.run ? RUNNING : STOPPED;

            if (ctrl.clear || transition) begin
                presc_q <= '0;
            end else if (state_q == RUNNING && ctrl.run) begin
                presc_q <= presc_term ? '0 : presc_q + 16'd1;
            end

            value_q <= ctrl.clear ? '0 : value_d;
            wrap_q  <= wrap_d;

            if (scan_q == SCAN_LAST) begin
                scan_q <= '0;
                idx_q  <= idx_q + 2'd1;
            end else begin
                scan_q <= scan_q + 16'd1;
            end

            // enable and segments register from the same index so they never skew
            digit_en_q <= 4'b0001 << idx_q;
            seg_q      <= seg_d;
        end
    end

    assign ctrl.value    = value_q;
    assign ctrl.wrap     = wrap_q;
    assign ctrl.running  = (state_q == RUNNING);
    assign ctrl.digit_en = digit_en_q;
    assign ctrl.seg      = seg_q;
endmodule

// File: tb/tb_octal_display_scan_controller.sv
// Self-checking bench: directed scenarios with literal pins plus a random phase
// checked every cycle against a behavioural model of the counter and display.
module tb_octal_display_scan_controller;
    localparam int P = 4;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    octal_display_scan_controller_if bus ();

    octal_display_scan_controller #(.PRESCALE(P), .SCAN_DIV(S)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    int m_val, m_pres, m_scan, m_idx, m_den, m_seg;
    bit m_st, m_wrap;

    int seg_tbl [8] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07};

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the spec's rules in plain integer arithmetic.
    always @(posedge clk) begin
        int val, pres, scan, idx;
        bit st, wr, cnt;
        if (rst) begin
            m_st <= 0; m_val <= 0; m_pres <= 0; m_wrap <= 0;
            m_scan <= 0; m_idx <= 0; m_den <= 1; m_seg <= 'h3F;
        end else begin
            st = m_st; pres = m_pres; val = m_val; wr = 0; cnt = 0;
            if (m_st != bus.run) begin st = bus.run; pres = 0; end
            if (bus.clear) begin
                val = 0; pres = 0;
            end else if (m_st && bus.run) begin
                if (m_pres == P - 1) begin pres = 0; cnt = 1; end
                else pres = m_pres + 1;
            end else if (!m_st && bus.step) begin
                cnt = 1;
            end
            if (cnt) begin
                if (bus.up_down) begin wr = (val == 4095); val = (val + 1) % 4096; end
                else begin wr = (val == 0); val = (val + 4095) % 4096; end
            end
            scan = (m_scan == S - 1) ? 0 : m_scan + 1;
            idx  = (m_scan == S - 1) ? (m_idx + 1) % 4 : m_idx;
            m_den  <= 1 << m_idx;
            m_seg  <= seg_tbl[(m_val >> (3 * m_idx)) & 7] | ((m_idx == 0 && m_st) ? 'h80 : 0);
            m_st   <= st;   m_pres <= pres; m_val <= val; m_wrap <= wr;
            m_scan <= scan; m_idx  <= idx;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_value", int'(bus.value), m_val);
            chk("model_wrap", int'(bus.wrap), int'(m_wrap));
            chk("model_running", int'(bus.running), int'(m_st));
            chk("model_digit_en", int'(bus.digit_en), m_den);
            chk("model_seg", int'(bus.seg), m_seg);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_value"}, int'(bus.value), 0);
        chk({tag, "_wrap"}, int'(bus.wrap), 0);
        chk({tag, "_running"}, int'(bus.running), 0);
        chk({tag, "_digit_en"}, int'(bus.digit_en), 1);
        chk({tag, "_seg"}, int'(bus.seg), 'h3F);
    endtask

    initial begin
        bit found;
        bus.run = 0; bus.step = 0; bus.up_down = 1; bus.clear = 0;
        rst = 1;
        tick(); tick();
        chk_reset_outputs("reset");
        rst = 0;
        cmp_en = 1;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_seg", int'(bus.seg), 'h3F);
            chk("idle_value", int'(bus.value), 0);
        end

        bus.run = 1; bus.up_down = 1;
        tick();
        chk("run_running", int'(bus.running), 1);
        for (int i = 0; i < 32; i++) tick();
        chk("run_value8", int'(bus.value), 8);
        bus.run = 0;
        tick();

        bus.clear = 1; tick(); bus.clear = 0;
        chk("clear_value", int'(bus.value), 0);
        bus.step = 1; bus.up_down = 0;
        tick();
        chk("down_wrap_value", int'(bus.value), 'o7777);
        chk("down_wrap_pulse", int'(bus.wrap), 1);
        tick();
        chk("down_value", int'(bus.value), 'o7776);
        chk("down_nowrap", int'(bus.wrap), 0);
        bus.up_down = 1;
        tick();
        chk("up_value", int'(bus.value), 'o7777);
        chk("up_nowrap", int'(bus.wrap), 0);
        tick();
        chk("up_wrap_value", int'(bus.value), 0);
        chk("up_wrap_pulse", int'(bus.wrap), 1);
        bus.step = 0;
        tick();
        chk("wrap_one_cycle", int'(bus.wrap), 0);

        bus.step = 1; bus.up_down = 0;
        tick();
        chk("step_down_value", int'(bus.value), 'o7777);
        chk("step_down_wrap", int'(bus.wrap), 1);
        bus.step = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.digit_en == 4'b0001) found = 1;
        end
        chk("digit0_found", int'(found), 1);
        chk("digit0_seg07", int'(bus.seg), 'h07);

        bus.clear = 1; tick(); bus.clear = 0;
        bus.step = 1; bus.up_down = 1;
        for (int i = 0; i < 83; i++) tick();
        bus.step = 0;
        chk("load_0123", int'(bus.value), 'o0123);
        bus.run = 1;
        tick();
        chk("clr_run_running", int'(bus.running), 1);
        for (int i = 0; i < 3; i++) tick();
        chk("clr_pre_value", int'(bus.value), 'o0123);
        bus.clear = 1;
        tick();
        bus.clear = 0;
        chk("clr_term_value", int'(bus.value), 0);
        chk("clr_term_wrap", int'(bus.wrap), 0);
        for (int i = 0; i < 3; i++) tick();
        chk("clr_restart_hold", int'(bus.value), 0);
        tick();
        chk("clr_restart_count", int'(bus.value), 1);

        for (int i = 0; i < 5; i++) tick();
        rst = 1;
        tick();
        chk_reset_outputs("midrst");
        rst = 0; bus.run = 0;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) bus.run = ~bus.run;
            bus.step    = $urandom_range(0, 1);
            bus.up_down = ($urandom_range(0, 7) != 0);
            bus.clear   = ($urandom_range(0, 31) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
